// File: rtl/core_mem_pkg.sv
// Shared types and helpers for the multiport memory model: response payload,
// byte-offset/strobe-width helpers and one-hot to index conversion.
package core_mem_pkg;

    localparam int unsigned MAX_PORTS  = 8;
    localparam int unsigned PORT_W     = 3;
    localparam int unsigned MAX_DATA_W = 64;

    typedef struct packed {
        logic                  valid;
        logic [PORT_W-1:0]     port;
        logic                  err;
        logic [MAX_DATA_W-1:0] data;
    } mem_resp_t;

    function automatic int unsigned strb_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned byte_offs(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic logic [PORT_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
        logic [PORT_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = PORT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from the
// pointer with wrap; pointer moves past the winner when a grant is taken.
module rr_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_j;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_next;
    logic          w_found;

    always_comb begin
        gnt_o   = '0;
        w_win   = '0;
        w_j     = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            w_j = PW'((32'(r_ptr) + k) % N);
            if (!w_found && req_i[w_j]) begin
                gnt_o[w_j] = 1'b1;
                w_win      = w_j;
                w_found    = 1'b1;
            end
        end
        w_next = (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (advance_i && w_found) begin
            r_ptr <= w_next;
        end
    end

    assign ptr_o = r_ptr;

endmodule

// File: rtl/multiport_mem_model.sv
// Multiport simulation memory: NUM_PORTS req/gnt/rvalid channels share one
// synchronous RAM bank through a round-robin arbiter and a latency pipeline.
module multiport_mem_model
    import core_mem_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 24,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned RAM_SEL_BIT = 31
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_PORTS-1:0]              req_i,
    output logic [NUM_PORTS-1:0]              gnt_o,
    input  logic [NUM_PORTS*64-1:0]           addr_i,
    input  logic [NUM_PORTS-1:0]              we_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]              rvalid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata_o,
    output logic [NUM_PORTS-1:0]              err_o
);

    localparam int unsigned STRB_W = strb_width(DATA_WIDTH);
    localparam int unsigned OFFS   = byte_offs(DATA_WIDTH);
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned NSTG   = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;
    localparam int unsigned PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]            w_gnt;
    logic [PW-1:0]                   w_unused_ptr;
    logic                            w_unused_addr;
    logic                            w_any;
    logic [PORT_W-1:0]               w_win;
    logic [63:0]                     w_addr;
    logic                            w_we;
    logic [STRB_W-1:0]               w_be;
    logic [DATA_WIDTH-1:0]           w_wdata;
    logic [ADDR_WIDTH-1:0]           w_idx;
    logic                            w_hit;
    mem_resp_t                       w_new;
    mem_resp_t                       w_last;

    logic [DATA_WIDTH-1:0]           r_mem [DEPTH];
    mem_resp_t                       r_pipe [NSTG];
    logic [NUM_PORTS-1:0]            r_rvalid;
    logic [NUM_PORTS-1:0]            r_err;
    logic [NUM_PORTS*DATA_WIDTH-1:0] r_rdata;

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .advance_i (w_any),
        .gnt_o     (w_gnt),
        .ptr_o     (w_unused_ptr)
    );

    assign w_any = |req_i;
    assign w_win = onehot_to_idx(MAX_PORTS'(w_gnt));

    // Winner payload mux
    always_comb begin
        w_addr  = '0;
        w_we    = 1'b0;
        w_be    = '0;
        w_wdata = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (w_gnt[p]) begin
                w_addr  = addr_i[p*64 +: 64];
                w_we    = we_i[p];
                w_be    = be_i[p*STRB_W +: STRB_W];
                w_wdata = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Bits above the index alias, so they are intentionally dropped
    assign w_idx         = w_addr[ADDR_WIDTH-1+OFFS -: ADDR_WIDTH];
    assign w_hit         = w_addr[RAM_SEL_BIT];
    assign w_unused_addr = ^w_addr;

    always_comb begin
        w_new       = '0;
        w_new.valid = w_any;
        w_new.port  = w_win;
        w_new.err   = w_any && !w_hit;
        if (w_any && w_hit && !w_we) begin
            w_new.data = MAX_DATA_W'(r_mem[w_idx]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_any && w_hit && w_we) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
        end
    end

    assign w_last = (RD_LATENCY == 1) ? w_new : r_pipe[NSTG-1];

    // Latency pipeline feeding the per-port response registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < NSTG; s++) r_pipe[s] <= '0;
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
        end else begin
            r_pipe[0] <= w_new;
            for (int unsigned s = 1; s < NSTG; s++) r_pipe[s] <= r_pipe[s-1];
            r_rvalid <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (w_last.valid && w_last.port == PORT_W'(p)) begin
                    r_rvalid[p]                         <= 1'b1;
                    r_err[p]                            <= w_last.err;
                    r_rdata[p*DATA_WIDTH +: DATA_WIDTH] <= w_last.data[DATA_WIDTH-1:0];
                end
            end
        end
    end

    assign gnt_o    = w_gnt;
    assign rvalid_o = r_rvalid;
    assign err_o    = r_err;
    assign rdata_o  = r_rdata;

endmodule

// File: tb/tb_multiport_mem_model.sv
// Directed bench: three 4-port instances (read latency 1, 2, 3) share one
// stimulus stream; each step checks grants and responses against hand values.
module tb_multiport_mem_model;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [255:0] addr;
    logic [3:0]   we;
    logic [31:0]  be;
    logic [255:0] wdata;

    logic [3:0]   gnt1, gnt2, gnt3;
    logic [3:0]   rvalid1, rvalid2, rvalid3;
    logic [3:0]   err1, err2, err3;
    logic [255:0] rdata1, rdata2, rdata3;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] V_FULL = 64'hDEADBEEF_CAFEBABE;
    localparam logic [63:0] V_A    = 64'hAAAAAAAA_BBBBBBBB;
    localparam logic [63:0] V_P    = 64'h11111111_22222222;
    localparam logic [63:0] V_MRG  = 64'hAAAAAAAA_22222222;
    localparam logic [63:0] V_C    = 64'h01234567_89ABCDEF;

    always #5 clk = ~clk;

    multiport_mem_model #(.NUM_PORTS(4), .DATA_WIDTH(64), .ADDR_WIDTH(10),
                          .RD_LATENCY(1), .RAM_SEL_BIT(31)) u_l1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt1), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid1),
        .rdata_o(rdata1), .err_o(err1));

    multiport_mem_model #(.NUM_PORTS(4), .DATA_WIDTH(64), .ADDR_WIDTH(10),
                          .RD_LATENCY(2), .RAM_SEL_BIT(31)) u_l2 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt2), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid2),
        .rdata_o(rdata2), .err_o(err2));

    multiport_mem_model #(.NUM_PORTS(4), .DATA_WIDTH(64), .ADDR_WIDTH(10),
                          .RD_LATENCY(3), .RAM_SEL_BIT(31)) u_l3 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt3), .addr_i(addr),
        .we_i(we), .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid3),
        .rdata_o(rdata3), .err_o(err3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic w, input logic [63:0] a,
                            input logic [7:0] b, input logic [63:0] d);
        req[p]          = 1'b1;
        we[p]           = w;
        addr[p*64 +: 64] = a;
        be[p*8 +: 8]     = b;
        wdata[p*64 +: 64] = d;
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; addr = '0; we = '0; be = '0; wdata = '0;
        idle(2);
        rst = 1'b0;
        #1;
        chk("reset_rvalid1", 256'(rvalid1), 256'(4'b0000));
        chk("reset_rvalid3", 256'(rvalid3), 256'(4'b0000));
        chk("reset_err1",    256'(err1),    256'(4'b0000));
        chk("reset_rdata1",  rdata1,        256'd0);
        chk("idle_gnt",      256'(gnt1),    256'(4'b0000));

        // Full write then read, port 0
        set_port(0, 1'b1, 64'h8000_0010, 8'hFF, V_FULL);
        chk("wr_gnt_same_cycle", 256'(gnt1), 256'(4'b0001));
        tick();
        chk("wr_resp_l1_valid", 256'(rvalid1), 256'(4'b0001));
        chk("wr_resp_l1_data",  rdata1[63:0], 256'd0);
        chk("wr_resp_l1_err",   256'(err1),   256'(4'b0000));
        chk("wr_resp_l2_early", 256'(rvalid2), 256'(4'b0000));
        set_port(0, 1'b0, 64'h8000_0010, 8'h00, 64'd0);
        chk("rd_gnt", 256'(gnt1), 256'(4'b0001));
        tick();
        req = '0;
        chk("rd_l1_valid", 256'(rvalid1), 256'(4'b0001));
        chk("rd_l1_data",  rdata1[63:0], 256'(V_FULL));
        chk("rd_l1_err",   256'(err1),   256'(4'b0000));
        chk("wr_resp_l2_valid", 256'(rvalid2), 256'(4'b0001));
        chk("wr_resp_l2_data",  rdata2[63:0], 256'd0);
        tick();
        chk("l1_single_cycle", 256'(rvalid1), 256'(4'b0000));
        chk("rd_l2_data", rdata2[63:0], 256'(V_FULL));
        chk("wr_resp_l3_valid", 256'(rvalid3), 256'(4'b0001));
        chk("wr_resp_l3_data",  rdata3[63:0], 256'd0);
        tick();
        chk("rd_l3_valid", 256'(rvalid3), 256'(4'b0001));
        chk("rd_l3_data",  rdata3[63:0], 256'(V_FULL));
        idle(4);

        // Partial write merge
        set_port(0, 1'b1, 64'h8000_0020, 8'hFF, V_A);
        tick();
        set_port(0, 1'b1, 64'h8000_0020, 8'h0F, V_P);
        tick();
        set_port(0, 1'b0, 64'h8000_0020, 8'h00, 64'd0);
        tick();
        req = '0;
        chk("partial_merge", rdata1[63:0], 256'(V_MRG));
        idle(4);

        // Round robin with all ports requesting after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int p = 0; p < 4; p++) set_port(p, 1'b0, 64'h8000_0010, 8'h00, 64'd0);
        for (int k = 0; k < 8; k++) begin
            chk("rr_gnt", 256'(gnt1), 256'(4'b0001 << (k % 4)));
            tick();
            chk("rr_rvalid", 256'(rvalid1), 256'(4'b0001 << (k % 4)));
            chk("rr_rdata",  rdata1[(k % 4)*64 +: 64], 256'(V_FULL));
        end
        req = '0;
        idle(4);

        // Unmapped address: error response, no write
        set_port(2, 1'b1, 64'h8000_1000, 8'hFF, V_C);
        tick();
        set_port(2, 1'b0, 64'h0000_1000, 8'h00, 64'd0);
        chk("miss_gnt", 256'(gnt1), 256'(4'b0100));
        tick();
        chk("miss_rd_valid", 256'(rvalid1), 256'(4'b0100));
        chk("miss_rd_err",   256'(err1),    256'(4'b0100));
        chk("miss_rd_data",  rdata1[191:128], 256'd0);
        set_port(2, 1'b1, 64'h0000_1000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("miss_wr_err", 256'(err1), 256'(4'b0100));
        set_port(2, 1'b0, 64'h8000_1000, 8'h00, 64'd0);
        tick();
        req = '0;
        chk("miss_wr_no_effect", rdata1[191:128], 256'(V_C));
        chk("hit_err_clear",     256'(err1),      256'(4'b0000));
        idle(4);

        // Back-to-back reads on port 1, latency 3
        set_port(1, 1'b0, 64'h8000_0010, 8'h00, 64'd0);
        chk("b2b_gnt", 256'(gnt3), 256'(4'b0010));
        tick();
        set_port(1, 1'b0, 64'h8000_0020, 8'h00, 64'd0);
        chk("b2b_l3_wait1", 256'(rvalid3), 256'(4'b0000));
        tick();
        set_port(1, 1'b0, 64'h8000_1000, 8'h00, 64'd0);
        chk("b2b_l3_wait2", 256'(rvalid3), 256'(4'b0000));
        tick();
        req = '0;
        chk("b2b_l3_v0", 256'(rvalid3), 256'(4'b0010));
        chk("b2b_l3_d0", rdata3[127:64], 256'(V_FULL));
        tick();
        chk("b2b_l3_v1", 256'(rvalid3), 256'(4'b0010));
        chk("b2b_l3_d1", rdata3[127:64], 256'(V_MRG));
        tick();
        chk("b2b_l3_v2", 256'(rvalid3), 256'(4'b0010));
        chk("b2b_l3_d2", rdata3[127:64], 256'(V_C));
        tick();
        chk("b2b_l3_done", 256'(rvalid3), 256'(4'b0000));
        idle(4);

        // Reset one cycle after a grant drops the in-flight response
        set_port(3, 1'b0, 64'h8000_0010, 8'h00, 64'd0);
        chk("flush_gnt", 256'(gnt2), 256'(4'b1000));
        tick();
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("flush_l2_none", 256'(rvalid2), 256'(4'b0000));
            chk("flush_l3_none", 256'(rvalid3), 256'(4'b0000));
            tick();
        end
        set_port(0, 1'b0, 64'h8000_0010, 8'h00, 64'd0);
        set_port(1, 1'b0, 64'h8000_0020, 8'h00, 64'd0);
        chk("post_rst_gnt_p0", 256'(gnt1), 256'(4'b0001));
        tick();
        req[0] = 1'b0;
        #1;
        chk("post_rst_gnt_p1", 256'(gnt1), 256'(4'b0010));
        chk("post_rst_rvalid", 256'(rvalid1), 256'(4'b0001));
        tick();
        req = '0;
        chk("post_rst_p1_data", rdata1[127:64], 256'(V_MRG));
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
